// File: rtl/key_schedule_ctrl_if.sv
// Link between the key schedule sequencer and the single-round key
// expansion stage. The sequencer is the master; the expansion stage is the slave.
interface key_schedule_ctrl_if;
    logic         xp_reset;
    logic         xp_enable;
    logic [127:0] xp_key_in;
    logic [3:0]   xp_key_num;
    logic [127:0] xp_key_out;
    logic         xp_done;

    modport master (
        output xp_reset, xp_enable, xp_key_in, xp_key_num,
        input  xp_key_out, xp_done
    );

    modport slave (
        input  xp_reset, xp_enable, xp_key_in, xp_key_num,
        output xp_key_out, xp_done
    );
endinterface

// File: rtl/key_schedule_ctrl.sv
// Key schedule sequencer. It loads a 128-bit cipher key and drives a
// single-round expansion stage through rounds 1..NUM_ROUNDS. It stores every
// round key and serves them through a registered read port.
// Optional build macro KEYSCHED_TIMEOUT_EN adds a per-round watchdog that
// aborts to IDLE and raises err when the expansion stage stalls.
module key_schedule_ctrl #(
    parameter int NUM_ROUNDS     = 10,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [127:0]            cipher_key,
    output logic                    busy,
    output logic                    keys_ready,
    input  logic [3:0]              rd_addr,
    output logic [127:0]            rd_key,
    output logic                    err,
    key_schedule_ctrl_if.master     xp
);

    // xp_key_num is 4 bits wide and must never wrap; the 5-bit watchdog
    // counter bounds the timeout.
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 14) begin : g_bad_rounds
        $error("key_schedule_ctrl: NUM_ROUNDS must be 1..14");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 31) begin : g_bad_timeout
        $error("key_schedule_ctrl: TIMEOUT_CYCLES must be 2..31");
    end

    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    typedef enum logic [2:0] {IDLE, LOAD, EXPAND, GAP, READY} state_t;

    state_t        state, state_d;
    logic [127:0]  kbuf [0:NUM_ROUNDS];
    logic [127:0]  key_cap;
    logic          armed;
    logic          tmo;
    logic          start_ok, do_load, do_cap, do_next, do_ready, do_abort;

`ifdef KEYSCHED_TIMEOUT_EN
    logic [4:0]    wd_cnt;
    logic          err_q;

    assign tmo = (wd_cnt == 5'(TIMEOUT_CYCLES - 1));
    assign err = err_q;

    // Watchdog: counts cycles spent in EXPAND or GAP and restarts on every state entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wd_cnt <= '0;
        else if (state_d != state || !(state == EXPAND || state == GAP))
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 5'd1;
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    // A start pulse in the first cycle after reset release is ignored.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) armed <= 1'b0;
        else        armed <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state logic and one-hot action strobes for the datapath.
    always_comb begin
        state_d  = state;
        start_ok = 1'b0;
        do_load  = 1'b0;
        do_cap   = 1'b0;
        do_next  = 1'b0;
        do_ready = 1'b0;
        do_abort = 1'b0;
        case (state)
            IDLE, READY: begin
                if (start && armed) begin
                    start_ok = 1'b1;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                do_load = 1'b1;
                state_d = EXPAND;
            end
            EXPAND: begin
                if (xp.xp_done) begin
                    do_cap  = 1'b1;
                    state_d = GAP;
                end else if (tmo) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end
            end
            GAP: begin
                if (!xp.xp_done) begin
                    if (xp.xp_key_num == LAST) begin
                        do_ready = 1'b1;
                        state_d  = READY;
                    end else begin
                        do_next = 1'b1;
                        state_d = EXPAND;
                    end
                end else if (tmo) begin
                    do_abort = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: key capture, buffer writes, expansion-stage drive and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_cap       <= '0;
            busy          <= 1'b0;
            keys_ready    <= 1'b0;
            xp.xp_reset   <= 1'b1;
            xp.xp_enable  <= 1'b0;
            xp.xp_key_in  <= '0;
            xp.xp_key_num <= '0;
            rd_key        <= '0;
            for (int i = 0; i <= NUM_ROUNDS; i++) kbuf[i] <= '0;
`ifdef KEYSCHED_TIMEOUT_EN
            err_q         <= 1'b0;
`endif
        end else begin
            rd_key <= (rd_addr <= LAST) ? kbuf[rd_addr] : '0;
            if (start_ok) begin
                key_cap    <= cipher_key;
                keys_ready <= 1'b0;
`ifdef KEYSCHED_TIMEOUT_EN
                err_q      <= 1'b0;
`endif
            end
            if (do_load) begin
                kbuf[0]       <= key_cap;
                xp.xp_key_in  <= key_cap;
                xp.xp_key_num <= 4'd1;
                xp.xp_reset   <= 1'b0;
                xp.xp_enable  <= 1'b1;
                busy          <= 1'b1;
                keys_ready    <= 1'b0;
            end
            if (do_cap) begin
                kbuf[xp.xp_key_num] <= xp.xp_key_out;
                xp.xp_key_in        <= xp.xp_key_out;
                xp.xp_enable        <= 1'b0;
            end
            if (do_next) begin
                xp.xp_key_num <= xp.xp_key_num + 4'd1;
                xp.xp_enable  <= 1'b1;
            end
            if (do_ready) begin
                busy        <= 1'b0;
                keys_ready  <= 1'b1;
                xp.xp_reset <= 1'b1;
            end
            if (do_abort) begin
                busy         <= 1'b0;
                xp.xp_enable <= 1'b0;
                xp.xp_reset  <= 1'b1;
`ifdef KEYSCHED_TIMEOUT_EN
                err_q        <= 1'b1;
`endif
            end
        end
    end

endmodule
